lc3_mem_responder: RTL

Synthesizable, parametrised instruction/data memory responder for the LC3 core. It replaces the fixed zero-wait behavioural memory model. It serves `instrmem_rd` fetches and `Data_rd`/`Data_wr` accesses through `complete_instr`/`complete_data` handshakes, with programmable wait states per channel. It also has a reset-time preload port, out-of-range detection and a fetch-budget "done" flag for the bench.

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/lc3_mem_chan.sv | 73 +++++++
 rtl/lc3_mem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
//   chan_state_e      : per-channel handshake FSM states
//   LC3_NOP           : word returned for out-of-range fetches (BR never)
//   DEFAULT_BASE_ADDR : address of instruction word 0
//   LAT_W             : width of the wait-state countdown counter
package lc3_mem_pkg;

    localparam int unsigned LAT_W             = 4;
    localparam logic [15:0] LC3_NOP           = 16'h0000;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

endpackage

// File: rtl/lc3_mem_chan.sv
// One request/complete handshake channel with programmable wait states.
//   clk, reset : clock, synchronous active-high reset
//   req        : request level (already gated by the caller)
//   accept_c   : request taken at this edge (combinational)
//   resp_c     : response is registered at this edge (combinational)
//   complete   : registered one-cycle completion pulse
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic accept_c,
    output logic resp_c,
    output logic complete
);

    chan_state_e             state_q, state_d;
    logic [LAT_W-1:0]        cnt_q, cnt_d;
    logic                    complete_q, complete_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            complete_q <= complete_d;
        end
    end

    // Accept / countdown / response; reset suppresses every strobe so an
    // in-flight access is aborted without a pulse or a memory write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_c   = 1'b0;
        resp_c     = 1'b0;
        complete_d = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        accept_c = 1'b1;
                        cnt_d    = LAT_W'(LAT);
                        if (LAT == 0) begin
                            resp_c = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        resp_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        complete_d = resp_c;
    end

    assign complete = complete_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Instruction/data memory responder for the LC3 core.
//   clk, reset                        : clock, synchronous active-high reset
//   instrmem_rd, pc                   : fetch request and address
//   Instr_dout, complete_instr        : fetched word and completion pulse
//   Data_rd, Data_wr, Data_addr,
//   Data_din                          : data access request
//   Data_dout, complete_data          : read data and completion pulse
//   ld_en, ld_sel, ld_addr, ld_data   : preload port, active only in reset
//   imem_oob, dmem_oob                : sticky out-of-range / conflict flags
//   fetch_cnt, done                   : accepted fetches, sticky budget flag
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       IMEM_DEPTH = 256,
    parameter int unsigned       DMEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int unsigned       IMEM_LAT   = 0,
    parameter int unsigned       DMEM_LAT   = 1,
    parameter int unsigned       MAX_FETCH  = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              Data_rd,
    input  logic              Data_wr,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic              ld_en,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              imem_oob,
    output logic              dmem_oob,
    output logic [31:0]       fetch_cnt,
    output logic              done
);

    localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [DATA_W-1:0] imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_dout_q, instr_dout_d;
    logic              imem_oob_q, imem_oob_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [DATA_W-1:0] d_din_q, d_din_d;
    logic              d_wr_q, d_wr_d;
    logic              d_conf_q, d_conf_d;
    logic [DATA_W-1:0] data_dout_q, data_dout_d;
    logic              dmem_oob_q, dmem_oob_d;

    logic              i_req_c, i_acc_c, i_resp_c, i_hit_c;
    logic [ADDR_W-1:0] i_idx_c;
    logic              d_req_c, d_acc_c, d_resp_c, d_hit_c;
    logic [ADDR_W-1:0] d_addr_c;
    logic [DATA_W-1:0] d_din_c;
    logic              d_wr_c, d_conf_c, dmem_we_c;
    logic              ld_ime_c, ld_dme_c;

    // Fetches stop being accepted once done is set
    assign i_req_c = instrmem_rd & ~done_q;
    assign d_req_c = Data_rd | Data_wr;

    lc3_mem_chan #(.LAT(IMEM_LAT)) u_ichan (
        .clk      (clk),
        .reset    (reset),
        .req      (i_req_c),
        .accept_c (i_acc_c),
        .resp_c   (i_resp_c),
        .complete (complete_instr)
    );

    lc3_mem_chan #(.LAT(DMEM_LAT)) u_dchan (
        .clk      (clk),
        .reset    (reset),
        .req      (d_req_c),
        .accept_c (d_acc_c),
        .resp_c   (d_resp_c),
        .complete (complete_data)
    );

    // Address capture, range checks, response data and status flags.
    // On a zero-latency channel accept and response share an edge, so the
    // live request fields are used instead of the captured ones.
    always_comb begin
        pc_d         = pc_q;
        instr_dout_d = instr_dout_q;
        imem_oob_d   = imem_oob_q;
        fetch_cnt_d  = fetch_cnt_q;
        done_d       = done_q;
        d_addr_d     = d_addr_q;
        d_din_d      = d_din_q;
        d_wr_d       = d_wr_q;
        d_conf_d     = d_conf_q;
        data_dout_d  = data_dout_q;
        dmem_oob_d   = dmem_oob_q;

        // Fetch path
        if (i_acc_c) begin
            pc_d = pc;
            if (fetch_cnt_q != '1) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end
        i_idx_c = (i_acc_c ? pc : pc_q) - BASE_ADDR;
        i_hit_c = 32'(i_idx_c) < IMEM_DEPTH;
        if (i_resp_c) begin
            instr_dout_d = i_hit_c ? imem_q[i_idx_c[IMEM_AW-1:0]] : DATA_W'(LC3_NOP);
            imem_oob_d   = imem_oob_q | ~i_hit_c;
        end
        done_d = done_q | (fetch_cnt_d >= 32'(MAX_FETCH)) | imem_oob_d;

        // Data path; rd+wr together degrades to a flagged read
        if (d_acc_c) begin
            d_addr_d = Data_addr;
            d_din_d  = Data_din;
            d_wr_d   = Data_wr & ~Data_rd;
            d_conf_d = Data_wr & Data_rd;
        end
        d_addr_c  = d_acc_c ? Data_addr : d_addr_q;
        d_din_c   = d_acc_c ? Data_din : d_din_q;
        d_wr_c    = d_acc_c ? (Data_wr & ~Data_rd) : d_wr_q;
        d_conf_c  = d_acc_c ? (Data_wr & Data_rd) : d_conf_q;
        d_hit_c   = 32'(d_addr_c) < DMEM_DEPTH;
        dmem_we_c = d_resp_c & d_wr_c & d_hit_c;
        if (d_resp_c) begin
            if (!d_wr_c) begin
                data_dout_d = d_hit_c ? dmem_q[d_addr_c[DMEM_AW-1:0]] : '0;
            end
            dmem_oob_d = dmem_oob_q | ~d_hit_c | d_conf_c;
        end

        // Preload strobes
        ld_ime_c = reset & ld_en & ~ld_sel & (32'(ld_addr) < IMEM_DEPTH);
        ld_dme_c = reset & ld_en &  ld_sel & (32'(ld_addr) < DMEM_DEPTH);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= '0;
            instr_dout_q <= '0;
            imem_oob_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            done_q       <= 1'b0;
            d_addr_q     <= '0;
            d_din_q      <= '0;
            d_wr_q       <= 1'b0;
            d_conf_q     <= 1'b0;
            data_dout_q  <= '0;
            dmem_oob_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_dout_q <= instr_dout_d;
            imem_oob_q   <= imem_oob_d;
            fetch_cnt_q  <= fetch_cnt_d;
            done_q       <= done_d;
            d_addr_q     <= d_addr_d;
            d_din_q      <= d_din_d;
            d_wr_q       <= d_wr_d;
            d_conf_q     <= d_conf_d;
            data_dout_q  <= data_dout_d;
            dmem_oob_q   <= dmem_oob_d;
        end
    end

    // Memory arrays: never cleared, so preloaded contents survive reset
    always_ff @(posedge clk) begin
        if (ld_ime_c) begin
            imem_q[ld_addr[IMEM_AW-1:0]] <= ld_data;
        end
        if (ld_dme_c) begin
            dmem_q[ld_addr[DMEM_AW-1:0]] <= ld_data;
        end else if (dmem_we_c) begin
            dmem_q[d_addr_c[DMEM_AW-1:0]] <= d_din_c;
        end
    end

    assign Instr_dout = instr_dout_q;
    assign imem_oob   = imem_oob_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign done       = done_q;
    assign Data_dout  = data_dout_q;
    assign dmem_oob   = dmem_oob_q;

endmodule
